// File: rtl/tmr_mem_pkg.sv
// rtl/tmr_mem_pkg.sv - shared types and memory geometry for the TMR scrubber
package tmr_mem_pkg;
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, S_RD, S_WAIT, S_WR} scrub_state_e;
endpackage

// File: rtl/scrub_timer.sv
// rtl/scrub_timer.sv - scrub interval down-counter and pending-step flag
module scrub_timer #(
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scrub_en,
  input  logic start,
  output logic pend
);
  localparam int CNT_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SCRUB_INTERVAL - 1);

  logic [CNT_W-1:0] cnt;

  // pend rises on the same edge the count lands on zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= LOAD;
      pend <= 1'b0;
    end else if (start) begin
      cnt  <= LOAD;
      pend <= 1'b0;
    end else if (scrub_en && !pend) begin
      if (cnt == '0) begin
        pend <= 1'b1;
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) pend <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/tmr_mem_scrubber.sv
// rtl/tmr_mem_scrubber.sv - host/scrub arbiter owning the triplicated SRAM port
module tmr_mem_scrubber
  import tmr_mem_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STARVE_MAX     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              scrub_pass_done,
  output logic [15:0]       scrub_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  scrub_state_e      state;
  logic              pend;
  logic              starved;
  logic              go;
  logic [SW-1:0]     starve_cnt;
  logic [DATA_W-1:0] scrub_buf;

  assign starved    = pend && (starve_cnt == SW'(STARVE_MAX));
  assign host_gnt   = host_req && (state == IDLE) && !starved;
  assign go         = (state == IDLE) && pend && (!host_req || starved);
  // the voted word arrives the cycle after the read edge, alongside rvalid
  assign host_rdata = host_rvalid ? mem_rdata : '0;

  // the interval counts only idle-port cycles, so steps sit SCRUB_INTERVAL+3 apart
  scrub_timer #(.SCRUB_INTERVAL(SCRUB_INTERVAL)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .scrub_en (scrub_en && (state == IDLE)),
    .start    (go),
    .pend     (pend)
  );

  always_comb begin
    mem_enable = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: if (host_gnt) begin
        mem_enable = 1'b1;
        mem_we     = host_we;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
      end
      S_RD: begin
        mem_enable = 1'b1;
        mem_addr   = scrub_addr;
      end
      S_WR: begin
        mem_enable = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = scrub_addr;
        mem_wdata  = scrub_buf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      scrub_buf       <= '0;
      scrub_addr      <= '0;
      scrub_count     <= '0;
      scrub_pass_done <= 1'b0;
      host_rvalid     <= 1'b0;
    end else begin
      scrub_pass_done <= 1'b0;
      host_rvalid     <= host_gnt && !host_we;
      case (state)
        IDLE: begin
          if (go) begin
            state      <= S_RD;
            starve_cnt <= '0;
          end else if (pend && host_gnt) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          scrub_buf <= mem_rdata;
          state     <= S_WR;
        end
        S_WR: begin
          state           <= IDLE;
          scrub_addr      <= scrub_addr + ADDR_W'(1);
          scrub_pass_done <= &scrub_addr;
          if (scrub_count != 16'hFFFF) scrub_count <= scrub_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
